// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder: FSM state encoding,
// word geometry and the access-rejection rule.
package mem_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_OFF_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Rejected when not word aligned or when the word index falls past the array.
    function automatic logic addr_bad(input logic [WORD_W-1:0] addr, input int unsigned depth);
        logic [WORD_W-1:0] idx;
        idx = {{BYTE_OFF_W{1'b0}}, addr[WORD_W-1:BYTE_OFF_W]};
        return (addr[BYTE_OFF_W-1:0] != '0) || (idx >= depth);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, with registered read data.
// Contents are not reset; only the read register is.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory behind a req/ready handshake with WAIT_CYCLES wait
// states; rejects misaligned and out-of-range accesses with err.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic              accept;
    logic              enter_resp;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              we_q;
    logic              err_q;
    logic [WORD_W-1:0] addr_sel;
    logic [WORD_W-1:0] ram_q;
    logic              ram_re;
    logic              ram_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    cnt_nxt   = WAIT_INIT;
                    state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states RESP is entered on the accepting edge, before
    // addr_q is loaded, so the read and error check look at the live address.
    assign addr_sel   = (state == IDLE) ? addr : addr_q;
    assign enter_resp = (state_nxt == RESP) && (state != RESP);
    assign ram_re     = enter_resp;
    assign ram_we     = (state == RESP) && we_q && !err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                we_q    <= we;
            end
            if (enter_resp) begin
                err_q <= addr_bad(addr_sel, DEPTH_WORDS);
            end
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .re      (ram_re),
        .we      (ram_we),
        .addr    (addr_sel[AW+BYTE_OFF_W-1:BYTE_OFF_W]),
        .wdata   (wdata_q),
        .rdata   (ram_q)
    );

    // ram_q and err_q both hold until the next response, so rdata does too.
    assign rdata = err_q ? '0 : ram_q;
    assign ready = (state == RESP);
    assign err   = ready && err_q;
    assign busy  = (state != IDLE);

    a_req_held: assert property (@(posedge clk) disable iff (!reset_n) (state != IDLE) |-> req)
        else $error("req dropped before ready");

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) driven by a
// vector table, hand sequences and random accesses checked against a model.
module tb_mem_responder;

    localparam int unsigned DEPTH = 256;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        req_v;
    logic [1:0]        we_v;
    logic [1:0][31:0]  addr_v;
    logic [1:0][31:0]  wdata_v;
    logic [1:0][31:0]  rdata_v;
    logic [1:0]        ready_v;
    logic [1:0]        err_v;
    logic [1:0]        busy_v;

    int checks = 0;
    int errors = 0;
    longint t_rdy;

    logic [31:0] model_mem   [2][DEPTH];
    bit          model_valid [2][DEPTH];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .reset_n(reset_n), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .rdata(rdata_v[0]), .ready(ready_v[0]), .err(err_v[0]), .busy(busy_v[0])
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset_n(reset_n), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .rdata(rdata_v[1]), .ready(ready_v[1]), .err(err_v[1]), .busy(busy_v[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic bit exp_err_of(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    // Call at a negedge. Holds req until the response, scrambles the inputs
    // after acceptance, then checks the one-cycle strobe and held rdata.
    task automatic do_access(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                             input bit keep, output logic [31:0] rd, output bit e, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        rd  = '0;
        e   = 1'b0;
        we_v[d] = w; addr_v[d] = a; wdata_v[d] = wd; req_v[d] = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ready_v[d]) got = 1'b1;
            if (i == 0) begin
                addr_v[d]  = $urandom;
                wdata_v[d] = $urandom;
                we_v[d]    = 1'($urandom_range(0, 1));
            end
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL timeout dut%0d addr=%h: ready=0 required=1", d, a);
            req_v[d] = 1'b0;
            return;
        end
        t_rdy = $time;
        rd = rdata_v[d];
        e  = err_v[d];
        @(posedge clk);
        #1;
        if (!keep) req_v[d] = 1'b0;
        @(negedge clk);
        chk("ready_one_cycle", 32'(ready_v[d]), 32'h0);
        chk("busy_after_resp", 32'(busy_v[d]), 32'h0);
        chk("rdata_held", rdata_v[d], rd);
    endtask

    task automatic check_access(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        bit e;
        int lat;
        bit xe;
        do_access(d, w, a, wd, 1'b0, rd, e, lat);
        xe = exp_err_of(a);
        chk("latency", 32'(lat), 32'(exp_lat(d)));
        chk("err", 32'(e), 32'(xe));
        if (xe) chk("err_rdata", rd, 32'h0);
        else if (!w && model_valid[d][a / 4]) chk("rdata", rd, model_mem[d][a / 4]);
        if (w && !xe) begin
            model_mem[d][a / 4]   = wd;
            model_valid[d][a / 4] = 1'b1;
        end
    endtask

    typedef struct {
        int          d;
        bit          w;
        logic [31:0] a;
        logic [31:0] wd;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          exp_e;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [31:0] rd, rd1;
        bit e;
        int lat;
        longint t1;

        req_v = '0; we_v = '0; addr_v = '0; wdata_v = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", 32'(ready_v[d]), 32'h0);
            chk("reset_err",   32'(err_v[d]),   32'h0);
            chk("reset_busy",  32'(busy_v[d]),  32'h0);
            chk("reset_rdata", rdata_v[d],      32'h0);
        end
        reset_n = 1'b1;
        @(negedge clk);

        tbl[0]  = '{0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{0, 1'b0, 32'h10,       32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{0, 1'b1, 32'h13,       32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
        tbl[3]  = '{0, 1'b0, 32'h10,       32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        tbl[4]  = '{0, 1'b0, 32'h400,      32'h0,        1'b1, 32'h0,        1'b1};
        tbl[5]  = '{1, 1'b1, 32'h0,        32'h12345678, 1'b0, 32'h0,        1'b0};
        tbl[6]  = '{1, 1'b0, 32'h0,        32'h0,        1'b1, 32'h12345678, 1'b0};
        tbl[7]  = '{0, 1'b1, 32'h3FC,      32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
        tbl[8]  = '{0, 1'b0, 32'h3FC,      32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
        tbl[9]  = '{0, 1'b0, 32'h3FE,      32'h0,        1'b1, 32'h0,        1'b1};
        tbl[10] = '{1, 1'b1, 32'hFFFFFFFC, 32'h55555555, 1'b1, 32'h0,        1'b1};

        for (int i = 0; i < 11; i++) begin
            do_access(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, 1'b0, rd, e, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(tbl[i].d)));
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].exp_e));
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            if (tbl[i].w && !tbl[i].exp_e) begin
                model_mem[tbl[i].d][tbl[i].a / 4]   = tbl[i].wd;
                model_valid[tbl[i].d][tbl[i].a / 4] = 1'b1;
            end
        end

        // Reset during WAIT: no response, outputs back to reset values, write dropped.
        check_access(0, 1'b1, 32'h20, 32'h11112222);
        we_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'hAAAAAAAA; req_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy_before_reset", 32'(busy_v[0]), 32'h1);
        reset_n = 1'b0;
        #1;
        req_v[0] = 1'b0;
        chk("mid_reset_busy",  32'(busy_v[0]),  32'h0);
        chk("mid_reset_ready", 32'(ready_v[0]), 32'h0);
        chk("mid_reset_err",   32'(err_v[0]),   32'h0);
        chk("mid_reset_rdata", rdata_v[0],      32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_reset_no_ready", 32'(ready_v[0]), 32'h0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check_access(0, 1'b0, 32'h20, 32'h0);
        chk("mid_reset_prior_data", model_mem[0][32'h20 / 4], 32'h11112222);

        // Back-to-back reads with req held high between them.
        for (int d = 0; d < 2; d++) begin
            check_access(d, 1'b1, 32'h0, 32'hA5A50001 + 32'(d));
            check_access(d, 1'b1, 32'h4, 32'h5A5A0004 + 32'(d));
            do_access(d, 1'b0, 32'h0, 32'h0, 1'b1, rd1, e, lat);
            t1 = t_rdy;
            do_access(d, 1'b0, 32'h4, 32'h0, 1'b0, rd, e, lat);
            chk("b2b_first_rdata",  rd1, 32'hA5A50001 + 32'(d));
            chk("b2b_second_rdata", rd,  32'hA5A5000 * 0 + 32'h5A5A0004 + 32'(d));
            chk("b2b_spacing", 32'((t_rdy - t1) / 10), (d == 0) ? 32'd4 : 32'd2);
        end

        for (int n = 0; n < 120; n++) begin
            int          d;
            bit          w;
            int unsigned sel;
            logic [31:0] a;
            d   = int'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 32'($urandom_range(0, 15)) * 4;
            else if (sel == 7) a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            else               a = $urandom | 32'h400;
            check_access(d, w, a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
